sram_responder: RTL



---
 rtl/sram_responder.sv | 101 ++++++++++
 1 files changed

// File: rtl/sram_responder.sv
// sram_responder: memory-side responder for the processor SRAM bus.
// Holds a DEPTH x DATA_W word array plus a boot loader. After reset the
// CPU is held stopped (cpu_run = 0) while a program is streamed in over a
// valid/ready port. The CPU is then released and served with
// combinational reads and synchronous writes.
//
// Ports:
//   clk, reset              clock (rising edge), async active-low reset
//   sram_addr/_we_n/_q      CPU word address, active-low write enable, write data
//   sram_d                  CPU read data (combinational, 0 while writing/out of range)
//   boot_valid/_data/_last  boot stream input; boot_last marks the final word
//   boot_ready              loader can accept a word
//   cpu_run                 1 = CPU released (drives the control FSM reset)
//   boot_count              words loaded in the current boot
//   addr_err                sticky out-of-range CPU access flag
module sram_responder #(
  parameter int ADDR_W = 8,   // must be < 16
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       sram_addr,
  input  logic              sram_we_n,
  input  logic [DATA_W-1:0] sram_q,
  output logic [DATA_W-1:0] sram_d,
  input  logic              boot_valid,
  input  logic [DATA_W-1:0] boot_data,
  input  logic              boot_last,
  output logic              boot_ready,
  output logic              cpu_run,
  output logic [ADDR_W:0]   boot_count,
  output logic              addr_err
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {BOOT, RUN} state_e;

  state_e              state_q, state_d;
  logic                rdy_q, run_q;
  logic                err_q, err_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                boot_hs, in_range, run_st, cpu_wr, mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [DATA_W-1:0]   mem_wd;

  assign run_st   = (state_q == RUN);
  assign in_range = (sram_addr[15:ADDR_W] == '0);
  // rdy_q lags the state by one edge, so the handshake is also gated by
  // state: a word offered in the cycle after the final one is ignored.
  assign boot_hs  = (state_q == BOOT) && rdy_q && boot_valid;
  assign cpu_wr   = run_st && !sram_we_n && in_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (boot_hs) begin
      cnt_d = cnt_q + 1'b1;
      // boot_last and array-full may coincide: single transition either way
      if (boot_last || (cnt_q[ADDR_W-1:0] == {ADDR_W{1'b1}})) state_d = RUN;
    end
    if (run_st && !in_range) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      rdy_q   <= 1'b0;
      run_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // registered from the current state: both flags change one edge
      // after the final boot write
      rdy_q   <= (state_q == BOOT);
      run_q   <= run_st;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Boot and CPU writes are mutually exclusive by state; array not reset.
  assign mem_we = boot_hs || cpu_wr;
  assign mem_wa = boot_hs ? cnt_q[ADDR_W-1:0] : sram_addr[ADDR_W-1:0];
  assign mem_wd = boot_hs ? boot_data : sram_q;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Combinational read so the FSM can latch the word in the cycle it
  // presents the address; no read-during-write forwarding.
  assign sram_d     = (run_st && sram_we_n && in_range) ? mem[sram_addr[ADDR_W-1:0]] : '0;
  assign boot_ready = rdy_q;
  assign cpu_run    = run_q;
  assign boot_count = cnt_q;
  assign addr_err   = err_q;
endmodule
